// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: fetches 9-bit instructions from ROM, decodes them and
// issues them to the register file with a Stall handshake, branch redirect and halt.
module instr_fetch_decode #(
    parameter int unsigned numReg    = 2,
    parameter int unsigned dataSize  = 8,
    parameter int unsigned instrSize = 9,
    parameter int unsigned pcSize    = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Start,
    input  logic [pcSize-1:0]    StartAddr,
    output logic                 InstrReq,
    output logic [pcSize-1:0]    InstrAddr,
    input  logic [instrSize-1:0] InstrData,
    input  logic                 InstrValid,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [pcSize-1:0]    BranchTarget,
    output logic                 IssueValid,
    output logic [numReg-1:0]    srcA,
    output logic [numReg-1:0]    srcB,
    output logic [numReg-1:0]    WriteReg,
    output logic                 RegWriteCtrl,
    output logic                 LoadImm,
    output logic [dataSize-1:0]  ImmData,
    output logic [2:0]           AluOp,
    output logic                 Done
);

    localparam int unsigned IMM_W = 4;
    localparam logic [2:0] OP_MISC = 3'b110;
    localparam logic [2:0] OP_LI   = 3'b111;
    localparam logic [1:0] FN_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [pcSize-1:0]   r_pc;
    logic [numReg-1:0]   r_src_a;
    logic [numReg-1:0]   r_src_b;
    logic [2:0]          r_alu_op;
    logic [IMM_W-1:0]    r_imm;
    logic                r_wr_en;
    logic                r_is_li;
    logic                r_halt;

    logic                w_start_ok;
    logic                w_latch;
    logic                w_accept;
    logic [2:0]          w_op;
    logic [1:0]          w_funct;

    assign w_start_ok = Start & ((r_state == S_IDLE) | (r_state == S_HALT));
    assign w_latch    = InstrValid & (r_state == S_FETCH);
    assign w_accept   = (r_state == S_ISSUE) & ~Stall;
    assign w_op       = InstrData[8:6];
    assign w_funct    = InstrData[1:0];

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start)      w_state_nxt = S_FETCH;
            S_FETCH: if (InstrValid) w_state_nxt = S_ISSUE;
            S_ISSUE: if (!Stall)     w_state_nxt = r_halt ? S_HALT : S_FETCH;
            S_HALT:  if (Start)      w_state_nxt = S_FETCH;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Program counter: load on start, advance or redirect on accepted issue, hold on halt
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc <= '0;
        end else if (w_start_ok) begin
            r_pc <= StartAddr;
        end else if (w_accept && !r_halt) begin
            r_pc <= BranchTaken ? BranchTarget : r_pc + pcSize'(1);
        end
    end

    // Decoded fields captured with the fetched word; held until the next fetch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_alu_op <= '0;
            r_imm    <= '0;
            r_wr_en  <= 1'b0;
            r_is_li  <= 1'b0;
            r_halt   <= 1'b0;
        end else if (w_latch) begin
            r_src_a  <= numReg'(InstrData[5:4]);
            r_src_b  <= numReg'(InstrData[3:2]);
            r_alu_op <= w_op;
            r_imm    <= InstrData[3:0];
            r_wr_en  <= (w_op != OP_MISC);
            r_is_li  <= (w_op == OP_LI);
            r_halt   <= (w_op == OP_MISC) && (w_funct == FN_HALT);
        end
    end

    assign InstrReq     = (r_state == S_FETCH);
    assign InstrAddr    = r_pc;
    assign IssueValid   = (r_state == S_ISSUE);
    assign srcA         = r_src_a;
    assign srcB         = r_src_b;
    assign WriteReg     = r_src_a;
    assign AluOp        = r_alu_op;
    assign ImmData      = {{(dataSize-IMM_W){1'b0}}, r_imm};
    // Write strobes gated by Stall so each instruction writes exactly once
    assign RegWriteCtrl = w_accept & r_wr_en;
    assign LoadImm      = w_accept & r_wr_en & r_is_li;
    assign Done         = (r_state == S_HALT);

endmodule
